// File: rtl/marquee_ctrl.sv
// Purpose: 12-LED marquee sequencer; four patterns, four speeds, run/pause from three raw buttons.
// Latency: a button edge updates mode/speed/paused/L on the 3rd clk edge; every output is registered.
// Backpressure: none; free-running timebase, and a button press preempts a step on the same cycle.
module marquee_ctrl #(
    parameter int unsigned DIV_BASE = 12_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        speed_btn,
    input  logic        pause_btn,
    output logic [11:0] Q,
    output logic [1:0]  mode,
    output logic [1:0]  speed,
    output logic        paused,
    output logic        step
);

    localparam logic [26:0] DIV = 27'(DIV_BASE);

    // Button bit order in the sync vectors: {pause, speed, mode}.
    logic [2:0]  btn_s1, btn_s2, btn_s3;
    logic [2:0]  press;
    logic        any_press;

    logic [26:0] cnt;
    logic [26:0] period;
    logic        terminal;
    logic        advance;

    // l is the lit vector (1 = lit); dir is the bounce direction (0 = inward).
    logic [11:0] l;
    logic        dir;
    logic [11:0] l_nxt;
    logic        dir_nxt;
    logic [1:0]  mode_inc;

    // Start pattern each mode reloads on entry and on illegal-state recovery.
    function automatic logic [11:0] start_pat(input logic [1:0] m);
        case (m)
            2'd0:    start_pat = 12'h801;
            2'd1:    start_pat = 12'h001;
            2'd2:    start_pat = 12'h800;
            default: start_pat = 12'h000;
        endcase
    endfunction

    // Three-flop synchronizer and edge detector for the raw buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= 3'b000;
            btn_s2 <= 3'b000;
            btn_s3 <= 3'b000;
        end else begin
            btn_s1 <= {pause_btn, speed_btn, mode_btn};
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
        end
    end

    assign press     = btn_s2 & ~btn_s3;
    assign any_press = |press;
    assign mode_inc  = mode + 2'd1;

    // Timebase: each speed step halves the period; any press suppresses the step.
    assign period   = DIV >> speed;
    assign terminal = (cnt == period - 27'd1);
    assign advance  = terminal & ~paused & ~any_press;

    // Next pattern for the current mode, falling back to the start pattern from any unreachable L.
    always_comb begin
        l_nxt   = start_pat(mode);
        dir_nxt = 1'b0;
        case (mode)
            2'd0: begin
                case (l)
                    12'h801: begin l_nxt = 12'h402; dir_nxt = 1'b0; end
                    12'h402: begin l_nxt = dir ? 12'h801 : 12'h204; dir_nxt = dir; end
                    12'h204: begin l_nxt = dir ? 12'h402 : 12'h108; dir_nxt = dir; end
                    12'h108: begin l_nxt = dir ? 12'h204 : 12'h090; dir_nxt = dir; end
                    12'h090: begin l_nxt = dir ? 12'h108 : 12'h060; dir_nxt = dir; end
                    12'h060: begin l_nxt = 12'h090; dir_nxt = 1'b1; end
                    default: begin l_nxt = 12'h801; dir_nxt = 1'b0; end
                endcase
            end
            2'd1: begin
                if (l != 12'h000 && (l & (l - 12'd1)) == 12'h000)
                    l_nxt = {l[10:0], l[11]};
            end
            2'd2: begin
                if (l != 12'h000 && (l & (l - 12'd1)) == 12'h000)
                    l_nxt = {l[0], l[11:1]};
            end
            default: begin
                // Legal fill states are contiguous low-order runs of ones (2^k - 1).
                if ((l & (l + 12'd1)) == 12'h000)
                    l_nxt = (l == 12'hFFF) ? 12'h000 : {l[10:0], 1'b1};
            end
        endcase
    end

    // Control and pattern registers; presses take effect independently in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode   <= 2'd0;
            speed  <= 2'd0;
            paused <= 1'b0;
            cnt    <= 27'd0;
            step   <= 1'b0;
            l      <= 12'h801;
            dir    <= 1'b0;
        end else begin
            step <= advance;

            if (press[0])
                mode <= mode_inc;
            if (press[1])
                speed <= speed + 2'd1;
            if (press[2])
                paused <= ~paused;

            if (press[0]) begin
                l   <= start_pat(mode_inc);
                dir <= 1'b0;
            end else if (advance) begin
                l   <= l_nxt;
                dir <= dir_nxt;
            end

            // Mode/speed restart the period; a pause press holds the count so resume continues it.
            if (press[0] | press[1])
                cnt <= 27'd0;
            else if (press[2])
                cnt <= cnt;
            else if (!paused)
                cnt <= terminal ? 27'd0 : cnt + 27'd1;
        end
    end

    assign Q = ~l;

endmodule

// File: tb/tb_marquee_ctrl.sv
// Directed bench for marquee_ctrl with DIV_BASE=8 (period 8/4/2/1 by speed).
// Clock period 10 ns; inputs change and outputs are sampled on the falling edge.
// Each task owns one scenario and compares against hand-derived values.
module tb_marquee_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_btn, speed_btn, pause_btn;
    logic [11:0] Q;
    logic [1:0]  mode, speed;
    logic        paused, step;

    int n_checks = 0;
    int n_fails  = 0;

    logic [11:0] fr_q [0:10] = '{12'h7FE, 12'hBFD, 12'hDFB, 12'hEF7, 12'hF6F, 12'hF9F,
                                 12'hF6F, 12'hEF7, 12'hDFB, 12'hBFD, 12'h7FE};

    marquee_ctrl #(.DIV_BASE(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_btn  (mode_btn),
        .speed_btn (speed_btn),
        .pause_btn (pause_btn),
        .Q         (Q),
        .mode      (mode),
        .speed     (speed),
        .paused    (paused),
        .step      (step)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        {pause_btn, speed_btn, mode_btn} = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Hold the given buttons across one rising edge; returns at the falling edge after the update edge.
    task automatic pulse(input logic [2:0] m);
        {pause_btn, speed_btn, mode_btn} = m;
        @(negedge clk);
        {pause_btn, speed_btn, mode_btn} = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {pause_btn, speed_btn, mode_btn} = 3'b000;
        repeat (3) @(negedge clk);
        n_checks += 1;
        if ({Q, mode, speed, paused, step} !== {12'h7FE, 2'd0, 2'd0, 1'b0, 1'b0}) begin
            n_fails += 1;
            $display("FAIL reset_state got Q=%h mode=%0d speed=%0d paused=%b step=%b exp Q=7fe 0 0 0 0",
                     Q, mode, speed, paused, step);
        end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            n_checks += 1;
            if ({step, Q} !== {(c % 8 == 0), fr_q[c / 8]}) begin
                n_fails += 1;
                $display("FAIL free_run c=%0d got step=%b Q=%h exp step=%b Q=%h",
                         c, step, Q, (c % 8 == 0), fr_q[c / 8]);
            end
        end
    endtask

    task automatic test_mode_cycle();
        logic [11:0] one;
        logic [11:0] exp_l;
        logic [12:0] t;
        do_reset();
        one = 12'h001;
        pulse(3'b001);
        n_checks += 1;
        if ({mode, Q, step} !== {2'd1, 12'hFFE, 1'b0}) begin
            n_fails += 1;
            $display("FAIL mode1_entry got mode=%0d Q=%h step=%b exp 1 ffe 0", mode, Q, step);
        end
        for (int k = 1; k <= 12; k++) begin
            repeat (8) @(negedge clk);
            exp_l = one << (k % 12);
            n_checks += 1;
            if ({step, Q} !== {1'b1, ~exp_l}) begin
                n_fails += 1;
                $display("FAIL rotl k=%0d got step=%b Q=%h exp 1 %h", k, step, Q, ~exp_l);
            end
        end
        pulse(3'b001);
        n_checks += 1;
        if ({mode, Q} !== {2'd2, 12'h7FF}) begin
            n_fails += 1;
            $display("FAIL mode2_entry got mode=%0d Q=%h exp 2 7ff", mode, Q);
        end
        repeat (8) @(negedge clk);
        n_checks += 1;
        if ({step, Q} !== {1'b1, 12'hBFF}) begin
            n_fails += 1;
            $display("FAIL rotr_1 got step=%b Q=%h exp 1 bff", step, Q);
        end
        repeat (8) @(negedge clk);
        n_checks += 1;
        if ({step, Q} !== {1'b1, 12'hDFF}) begin
            n_fails += 1;
            $display("FAIL rotr_2 got step=%b Q=%h exp 1 dff", step, Q);
        end
        pulse(3'b001);
        n_checks += 1;
        if ({mode, Q} !== {2'd3, 12'hFFF}) begin
            n_fails += 1;
            $display("FAIL mode3_entry got mode=%0d Q=%h exp 3 fff", mode, Q);
        end
        for (int k = 1; k <= 13; k++) begin
            repeat (8) @(negedge clk);
            t = (13'd1 << k) - 13'd1;
            exp_l = (k == 13) ? 12'h000 : t[11:0];
            n_checks += 1;
            if ({step, Q} !== {1'b1, ~exp_l}) begin
                n_fails += 1;
                $display("FAIL fill k=%0d got step=%b Q=%h exp 1 %h", k, step, Q, ~exp_l);
            end
        end
        pulse(3'b001);
        n_checks += 1;
        if ({mode, Q} !== {2'd0, 12'h7FE}) begin
            n_fails += 1;
            $display("FAIL mode0_wrap got mode=%0d Q=%h exp 0 7fe", mode, Q);
        end
    endtask

    task automatic test_speed();
        do_reset();
        pulse(3'b010);
        n_checks += 1;
        if ({speed, step, Q} !== {2'd1, 1'b0, 12'h7FE}) begin
            n_fails += 1;
            $display("FAIL speed1_entry got speed=%0d step=%b Q=%h exp 1 0 7fe", speed, step, Q);
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks += 1;
            if (step !== (c % 4 == 0)) begin
                n_fails += 1;
                $display("FAIL speed1_spacing c=%0d got step=%b exp %b", c, step, (c % 4 == 0));
            end
        end
        pulse(3'b010);
        n_checks += 1;
        if ({speed, step} !== {2'd2, 1'b0}) begin
            n_fails += 1;
            $display("FAIL speed2_entry got speed=%0d step=%b exp 2 0", speed, step);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks += 1;
            if (step !== (c % 2 == 0)) begin
                n_fails += 1;
                $display("FAIL speed2_spacing c=%0d got step=%b exp %b", c, step, (c % 2 == 0));
            end
        end
        pulse(3'b010);
        n_checks += 1;
        if ({speed, step} !== {2'd3, 1'b0}) begin
            n_fails += 1;
            $display("FAIL speed3_entry got speed=%0d step=%b exp 3 0", speed, step);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_checks += 1;
            if (step !== 1'b1) begin
                n_fails += 1;
                $display("FAIL speed3_spacing c=%0d got step=%b exp 1", c, step);
            end
        end
        pulse(3'b010);
        n_checks += 1;
        if ({speed, step} !== {2'd0, 1'b0}) begin
            n_fails += 1;
            $display("FAIL speed_wrap got speed=%0d step=%b exp 0 0", speed, step);
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks += 1;
            if (step !== (c == 8)) begin
                n_fails += 1;
                $display("FAIL speed0_spacing c=%0d got step=%b exp %b", c, step, (c == 8));
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        // The pause press lands on edge 3, holding cnt at 2.
        pulse(3'b100);
        n_checks += 1;
        if (paused !== 1'b1) begin
            n_fails += 1;
            $display("FAIL pause_on got paused=%b exp 1", paused);
        end
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            n_checks += 1;
            if ({step, Q} !== {1'b0, 12'h7FE}) begin
                n_fails += 1;
                $display("FAIL paused_hold c=%0d got step=%b Q=%h exp 0 7fe", c, step, Q);
            end
        end
        pulse(3'b100);
        n_checks += 1;
        if (paused !== 1'b0) begin
            n_fails += 1;
            $display("FAIL pause_off got paused=%b exp 0", paused);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_checks += 1;
            if ({step, Q} !== {(c == 6), (c == 6) ? 12'hBFD : 12'h7FE}) begin
                n_fails += 1;
                $display("FAIL resume c=%0d got step=%b Q=%h exp %b %h",
                         c, step, Q, (c == 6), (c == 6) ? 12'hBFD : 12'h7FE);
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        // Mode press timed to land on edge 8, the terminal-count cycle.
        repeat (5) @(negedge clk);
        pulse(3'b001);
        n_checks += 1;
        if ({step, mode, Q} !== {1'b0, 2'd1, 12'hFFE}) begin
            n_fails += 1;
            $display("FAIL press_at_terminal got step=%b mode=%0d Q=%h exp 0 1 ffe", step, mode, Q);
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks += 1;
            if ({step, Q} !== {(c == 8), (c == 8) ? 12'hFFD : 12'hFFE}) begin
                n_fails += 1;
                $display("FAIL after_terminal_press c=%0d got step=%b Q=%h", c, step, Q);
            end
        end
        pulse(3'b011);
        n_checks += 1;
        if ({mode, speed, Q} !== {2'd2, 2'd1, 12'h7FF}) begin
            n_fails += 1;
            $display("FAIL mode_speed_together got mode=%0d speed=%0d Q=%h exp 2 1 7ff", mode, speed, Q);
        end
        repeat (4) @(negedge clk);
        n_checks += 1;
        if ({step, Q} !== {1'b1, 12'hBFF}) begin
            n_fails += 1;
            $display("FAIL mode_speed_step got step=%b Q=%h exp 1 bff", step, Q);
        end
        // Button held through reset release: exactly one press, landing on edge 3.
        reset = 1'b1;
        mode_btn = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 1;
        if (mode !== 2'd0) begin
            n_fails += 1;
            $display("FAIL held_reset_early got mode=%0d exp 0", mode);
        end
        @(negedge clk);
        n_checks += 1;
        if ({mode, Q} !== {2'd1, 12'hFFE}) begin
            n_fails += 1;
            $display("FAIL held_reset_press got mode=%0d Q=%h exp 1 ffe", mode, Q);
        end
        repeat (10) @(negedge clk);
        mode_btn = 1'b0;
        repeat (5) @(negedge clk);
        n_checks += 1;
        if (mode !== 2'd1) begin
            n_fails += 1;
            $display("FAIL held_reset_single got mode=%0d exp 1", mode);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse(3'b001);
        pulse(3'b001);
        pulse(3'b010);
        pulse(3'b010);
        pulse(3'b010);
        pulse(3'b100);
        n_checks += 1;
        if ({mode, speed, paused} !== {2'd2, 2'd3, 1'b1}) begin
            n_fails += 1;
            $display("FAIL async_setup got mode=%0d speed=%0d paused=%b exp 2 3 1", mode, speed, paused);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks += 1;
        if (Q !== 12'h7FE) begin
            n_fails += 1;
            $display("FAIL async_Q got %h exp 7fe", Q);
        end
        n_checks += 1;
        if ({mode, speed} !== 4'd0) begin
            n_fails += 1;
            $display("FAIL async_mode_speed got mode=%0d speed=%0d exp 0 0", mode, speed);
        end
        n_checks += 1;
        if ({paused, step} !== 2'b00) begin
            n_fails += 1;
            $display("FAIL async_paused_step got paused=%b step=%b exp 0 0", paused, step);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_mode_cycle();
        test_speed();
        test_pause();
        test_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
